// File: rtl/mips_pkg.sv
// Shared MIPS core constants: instruction word geometry and word-alignment helper.
package mips_pkg;
   localparam int INSTR_WIDTH = 32;
   localparam int INSTR_BYTES = 4;
   // Low address bits that select a byte within an instruction word.
   localparam int WORD_MASK   = INSTR_BYTES - 1;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {instruction, pc} entries, with single-cycle flush.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_s;
   logic             pop_s;

   assign empty     = (count_r == {CW{1'b0}});
   assign full      = (count_r == CW'(DEPTH));
   assign count     = count_r;
   assign head_data = mem_r[rd_ptr_r];
   assign pop_s     = pop && !empty;
   assign push_s    = push && (!full || pop_s);

   // Pointer and occupancy tracking; flush wins over push/pop.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
         else        wr_ptr_r <= wr_ptr_r;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1'b1);
         else        rd_ptr_r <= rd_ptr_r;
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
      end else if (push_s && !flush) begin
         mem_r[wr_ptr_r] <= push_data;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end
endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: PC sequencing, credit-limited imem requests,
// redirect handling and a decoupling queue toward decode.
module mips_fetch_unit
   import mips_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc,
   output logic                   imem_req,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic [31:0]            imem_rdata,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [31:0]            instr,
   output logic [ADDR_WIDTH-1:0]  instr_pc,
   output logic [ADDR_WIDTH-1:0]  pc_curr
);
   localparam int                    CW         = $clog2(DEPTH+1);
   localparam int                    EW         = INSTR_WIDTH + ADDR_WIDTH;
   localparam logic [CW:0]           DEPTH_LIM  = (CW+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WORD_MASK);

   logic [ADDR_WIDTH-1:0] pc_r;
   logic [ADDR_WIDTH-1:0] inflight_pc_r;
   logic                  inflight_r;
   logic [CW-1:0]         count_s;
   logic [CW:0]           credit_used_s;
   logic                  empty_s;
   logic                  full_s;
   logic                  req_s;
   logic                  push_s;
   logic                  pop_s;
   logic [EW-1:0]         head_s;

   // Buffered plus in-flight fetches must fit the queue; a same-cycle pop gives no credit.
   assign credit_used_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
   assign req_s  = reset && !redirect_valid && !full_s && (credit_used_s < DEPTH_LIM);
   assign push_s = inflight_r && !redirect_valid;
   assign pop_s  = instr_valid && instr_ready && !redirect_valid;

   assign imem_req    = req_s;
   assign imem_addr   = pc_r;
   assign pc_curr     = pc_r;
   assign instr_valid = !empty_s;
   assign instr       = instr_valid ? head_s[EW-1:ADDR_WIDTH] : {INSTR_WIDTH{1'b0}};
   assign instr_pc    = instr_valid ? head_s[ADDR_WIDTH-1:0]  : {ADDR_WIDTH{1'b0}};

   // PC and in-flight tracking; redirect has highest priority and kills the pending response.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_r          <= RESET_PC;
         inflight_r    <= 1'b0;
         inflight_pc_r <= {ADDR_WIDTH{1'b0}};
      end else if (redirect_valid) begin
         pc_r          <= redirect_pc & ALIGN_MASK;
         inflight_r    <= 1'b0;
         inflight_pc_r <= inflight_pc_r;
      end else if (req_s) begin
         pc_r          <= pc_r + PC_STEP;
         inflight_r    <= 1'b1;
         inflight_pc_r <= pc_r;
      end else begin
         pc_r          <= pc_r;
         inflight_r    <= 1'b0;
         inflight_pc_r <= inflight_pc_r;
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_queue (
      .clock     (clock),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (push_s),
      .push_data ({imem_rdata, inflight_pc_r}),
      .pop       (pop_s),
      .head_data (head_s),
      .count     (count_s),
      .empty     (empty_s),
      .full      (full_s)
   );
endmodule
